fir_ram_mac_ch: RTL and testbench

Multi-channel, pipelined multiply-accumulate engine for RAM-based time-multiplexed FIR filters. It is the successor of the single-accumulator MAC. It adds:
- per-channel accumulators selected by a channel tag
- framing (first/last tap) instead of an external clear-then-accumulate sequence
- full-precision accumulation with guard bits
- round-half-up and saturation to a configurable output width, with a result-valid strobe

It sits between the coefficient/delay-line RAM sequencer and the filter output register.

---
 rtl/fir_ram_mac_ch.sv | 172 +++++++++++++++++
 tb/tb_fir_ram_mac_ch.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_ram_mac_ch.sv
// Multi-channel pipelined MAC for time-multiplexed FIR filters: per-channel guarded
// accumulators, first/last framing, round-half-up and saturation to OUT_WIDTH.
module fir_ram_mac_ch #(
    parameter  int DATA_WIDTH = 16,
    parameter  int COEF_WIDTH = 16,
    parameter  int GUARD_BITS = 4,
    localparam int ACC_WIDTH  = DATA_WIDTH + COEF_WIDTH + GUARD_BITS,
    parameter  int OUT_WIDTH  = 16,
    parameter  int OUT_SHIFT  = COEF_WIDTH - 1,
    parameter  int CH_NUM     = 4,
    localparam int CH_W       = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         clr_i,
    input  logic                         ena_i,
    input  logic                         first_i,
    input  logic                         last_i,
    input  logic [CH_W-1:0]              ch_i,
    input  logic signed [DATA_WIDTH-1:0] data_i,
    input  logic signed [COEF_WIDTH-1:0] coef_i,
    output logic [OUT_WIDTH-1:0]         res_o,
    output logic [CH_W-1:0]              res_ch_o,
    output logic                         res_valid_o,
    output logic                         ovf_o
);

    localparam int PW = DATA_WIDTH + COEF_WIDTH;
    localparam int AW = ACC_WIDTH;

    localparam logic [CH_W:0]        CH_LIM = (CH_W + 1)'(CH_NUM);
    localparam logic signed [AW:0]   RND_V  = ((AW + 1)'(1) << OUT_SHIFT) >> 1;
    localparam logic signed [AW:0]   MAX_V  = {{(AW + 2 - OUT_WIDTH){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [AW:0]   MIN_V  = ~MAX_V;

    generate
        if (OUT_SHIFT >= ACC_WIDTH || OUT_WIDTH > ACC_WIDTH || CH_NUM < 1) begin : g_bad_params
            $error("fir_ram_mac_ch: illegal parameter combination");
        end
    endgenerate

    // S1: full-precision product and tap tags
    logic signed [PW-1:0] prod_q;
    logic                 s1_vld_q, s1_first_q, s1_last_q;
    logic [CH_W-1:0]      s1_ch_q;
    logic                 tap_ok;

    assign tap_ok = ena_i && ({1'b0, ch_i} < CH_LIM);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prod_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_ch_q    <= '0;
        end else begin
            prod_q     <= PW'(data_i) * PW'(coef_i);
            s1_vld_q   <= tap_ok && !clr_i;
            s1_first_q <= first_i;
            s1_last_q  <= last_i;
            s1_ch_q    <= ch_i;
        end
    end

    // S2: channel accumulators; a same-channel tap next cycle sees this write
    logic signed [AW-1:0] acc_q [CH_NUM];
    logic signed [AW-1:0] acc_sel, prod_ext, sum_d;
    logic signed [AW-1:0] s2_sum_q;
    logic                 s2_vld_q;
    logic [CH_W-1:0]      s2_ch_q;

    always_comb begin
        acc_sel = '0;
        for (int i = 0; i < CH_NUM; i++) begin
            if (s1_ch_q == CH_W'(i)) acc_sel = acc_q[i];
        end
        prod_ext = AW'(prod_q);
        sum_d    = s1_first_q ? prod_ext : acc_sel + prod_ext;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < CH_NUM; i++) acc_q[i] <= '0;
            s2_sum_q <= '0;
            s2_vld_q <= 1'b0;
            s2_ch_q  <= '0;
        end else if (clr_i) begin
            for (int i = 0; i < CH_NUM; i++) acc_q[i] <= '0;
            s2_vld_q <= 1'b0;
        end else begin
            for (int i = 0; i < CH_NUM; i++) begin
                if (s1_vld_q && s1_ch_q == CH_W'(i)) acc_q[i] <= sum_d;
            end
            s2_vld_q <= s1_vld_q && s1_last_q;
            if (s1_vld_q && s1_last_q) begin
                s2_sum_q <= sum_d;
                s2_ch_q  <= s1_ch_q;
            end
        end
    end

    // S3: round half up and shift, one extra bit so the rounding add cannot wrap
    logic signed [AW:0] rnd_sum, shr;
    logic signed [AW:0] r_q;
    logic               r_vld_q;
    logic [CH_W-1:0]    r_ch_q;

    always_comb begin
        rnd_sum = $signed({s2_sum_q[AW-1], s2_sum_q}) + RND_V;
        shr     = rnd_sum >>> OUT_SHIFT;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_q     <= '0;
            r_vld_q <= 1'b0;
            r_ch_q  <= '0;
        end else if (clr_i) begin
            r_vld_q <= 1'b0;
        end else begin
            r_vld_q <= s2_vld_q;
            if (s2_vld_q) begin
                r_q    <= shr;
                r_ch_q <= s2_ch_q;
            end
        end
    end

    // Output stage: saturate and register, values hold between strobes
    logic [OUT_WIDTH-1:0] sat_res;
    logic                 sat_ovf;
    logic [OUT_WIDTH-1:0] res_q;
    logic [CH_W-1:0]      res_ch_q;
    logic                 res_vld_q, ovf_q;

    always_comb begin
        sat_res = r_q[OUT_WIDTH-1:0];
        sat_ovf = 1'b0;
        if (r_q > MAX_V) begin
            sat_res = MAX_V[OUT_WIDTH-1:0];
            sat_ovf = 1'b1;
        end else if (r_q < MIN_V) begin
            sat_res = MIN_V[OUT_WIDTH-1:0];
            sat_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            res_q     <= '0;
            res_ch_q  <= '0;
            res_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (clr_i) begin
            res_vld_q <= 1'b0;
        end else begin
            res_vld_q <= r_vld_q;
            if (r_vld_q) begin
                res_q    <= sat_res;
                res_ch_q <= r_ch_q;
                ovf_q    <= sat_ovf;
            end
        end
    end

    assign res_o       = res_q;
    assign res_ch_o    = res_ch_q;
    assign res_valid_o = res_vld_q;
    assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_fir_ram_mac_ch.sv
// Scoreboard bench for fir_ram_mac_ch: default 4-channel build plus a 5-channel build
// used to exercise out-of-range channel dropping.
module tb_fir_ram_mac_ch;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n, clr, ena, first, last;
    logic [1:0]         ch;
    logic signed [15:0] data, coef;
    logic [15:0]        res;
    logic [1:0]         res_ch;
    logic               res_valid, ovf;

    logic               ena5;
    logic [2:0]         ch5;
    logic [15:0]        res5;
    logic [2:0]         res_ch5;
    logic               rv5, ovf5;

    fir_ram_mac_ch dut (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .ena_i(ena), .first_i(first),
        .last_i(last), .ch_i(ch), .data_i(data), .coef_i(coef), .res_o(res),
        .res_ch_o(res_ch), .res_valid_o(res_valid), .ovf_o(ovf)
    );

    fir_ram_mac_ch #(.CH_NUM(5)) dut5 (
        .clk_i(clk), .rst_n_i(rst_n), .clr_i(clr), .ena_i(ena5), .first_i(first),
        .last_i(last), .ch_i(ch5), .data_i(data), .coef_i(coef), .res_o(res5),
        .res_ch_o(res_ch5), .res_valid_o(rv5), .ovf_o(ovf5)
    );

    typedef struct {
        logic [15:0] res;
        logic [1:0]  ch;
        logic        ovf;
        int          at;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_edge = 0;
    int   strobe5_cnt = 0;
    longint model_acc [4];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && res_valid) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_strobe: got res=%0d ch=%0d ovf=%0b at edge %0d, required no strobe",
                         $signed(res), res_ch, ovf, cyc);
            end else begin
                mon_e = sb.pop_front();
                if (res !== mon_e.res || res_ch !== mon_e.ch || ovf !== mon_e.ovf || cyc != mon_e.at) begin
                    errors++;
                    $display("FAIL strobe: got res=%0d ch=%0d ovf=%0b edge=%0d, required res=%0d ch=%0d ovf=%0b edge=%0d",
                             $signed(res), res_ch, ovf, cyc, $signed(mon_e.res), mon_e.ch, mon_e.ovf, mon_e.at);
                end else begin
                    $display("strobe ok: res=%0d ch=%0d ovf=%0b edge=%0d", $signed(res), res_ch, ovf, cyc);
                end
            end
        end
        if (rst_n && rv5) strobe5_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ena = 1'b0; ena5 = 1'b0; first = 1'b0; last = 1'b0; clr = 1'b0;
        end
    endtask

    task automatic tap(input logic f, input logic l, input logic [1:0] c, input int d, input int k);
        @(negedge clk);
        ena = 1'b1; ena5 = 1'b0; first = f; last = l; ch = c; clr = 1'b0;
        data = 16'(d); coef = 16'(k);
        if (l) last_edge = cyc + 1;
    endtask

    task automatic expect_res(input int r, input logic [1:0] c, input logic o);
        exp_t e;
        e.res = 16'(r); e.ch = c; e.ovf = o; e.at = last_edge + 3;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 20) begin
            idle(1);
            n++;
        end
        idle(2);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_missing: got %0d results outstanding, required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        idle(3);
        checks++;
        if ({res, res_ch, res_valid, ovf} !== '0 || {res5, res_ch5, rv5, ovf5} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got res=%h ch=%0d v=%0b ovf=%0b, required all 0", res, res_ch, res_valid, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_basic;
        tap(1, 0, 0, 16384, 16384);
        tap(0, 0, 0, 16384, 16384);
        tap(0, 1, 0, 16384, 16384);
        expect_res(24576, 0, 0);
        drain("basic");
    endtask

    task automatic test_rounding;
        tap(1, 1, 0, 1, 16384);
        expect_res(1, 0, 0);
        tap(1, 1, 3, -1, 16384);
        expect_res(0, 3, 0);
        tap(1, 1, 1, 3, 16384);
        expect_res(2, 1, 0);
        drain("rounding");
    endtask

    task automatic test_saturation;
        for (int i = 0; i < 4; i++) tap(i == 0, i == 3, 2, 32767, 32767);
        expect_res(32767, 2, 1);
        for (int i = 0; i < 4; i++) tap(i == 0, i == 3, 3, -32768, 32767);
        expect_res(-32768, 3, 1);
        tap(1, 1, 1, 32767, 32767);
        expect_res(32766, 1, 0);
        drain("saturation");
    endtask

    task automatic test_interleave;
        tap(1, 0, 0, 200, 16384);
        tap(1, 0, 1, -50, 16384);
        tap(0, 1, 0, 200, 16384);
        expect_res(200, 0, 0);
        tap(0, 1, 1, -50, 16384);
        expect_res(-50, 1, 0);
        drain("interleave");
    endtask

    task automatic test_bubbles;
        tap(1, 0, 2, 16384, 16384);
        idle(2);
        tap(0, 0, 2, 16384, 16384);
        idle(2);
        tap(0, 1, 2, 16384, 16384);
        expect_res(24576, 2, 0);
        drain("bubbles");
    endtask

    task automatic test_clear;
        tap(1, 0, 0, 16384, 16384);
        tap(0, 0, 0, 16384, 16384);
        @(negedge clk);
        ena = 1'b0; first = 1'b0; last = 1'b0; clr = 1'b1;
        tap(0, 1, 0, 16384, 16384);
        expect_res(8192, 0, 0);
        drain("clear");
        tap(1, 1, 1, 16384, 16384);
        @(negedge clk);
        ena = 1'b0; first = 1'b0; last = 1'b0; clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_kill: got res_valid=%0b after clr, required 0", res_valid);
        end
        drain("clear_kill");
    endtask

    // Five-channel build: channel 4 is legal, 5 and 7 are out of range
    task automatic test_drop;
        int base;
        base = strobe5_cnt;
        @(negedge clk);
        ena = 1'b0; ena5 = 1'b1; first = 1'b1; last = 1'b1; ch5 = 3'd5; data = 16'sd16384; coef = 16'sd16384;
        @(negedge clk);
        ch5 = 3'd7;
        @(negedge clk);
        ch5 = 3'd4; data = 16'sd8192;
        idle(8);
        checks++;
        if (strobe5_cnt - base != 1 || res5 !== 16'd4096 || res_ch5 !== 3'd4 || ovf5 !== 1'b0) begin
            errors++;
            $display("FAIL drop: got %0d strobes res=%0d ch=%0d, required 1 strobe res=4096 ch=4",
                     strobe5_cnt - base, $signed(res5), res_ch5);
        end else begin
            $display("drop ok: only ch4 strobed, res=%0d", $signed(res5));
        end
    endtask

    task automatic test_reset_mid;
        tap(1, 0, 0, 16384, 16384);
        tap(0, 0, 0, 16384, 16384);
        @(negedge clk);
        ena = 1'b0; first = 1'b0; last = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({res, res_ch, res_valid, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got res=%h ch=%0d v=%0b ovf=%0b, required all 0", res, res_ch, res_valid, ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(6);
        checks++;
        if ({res, res_ch, res_valid, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_mid_hold: got res=%h ch=%0d v=%0b ovf=%0b, required all 0", res, res_ch, res_valid, ovf);
        end
        tap(0, 1, 0, 16384, 16384);
        expect_res(8192, 0, 0);
        drain("reset_mid");
    endtask

    task automatic test_random;
        logic [1:0] c;
        logic       f, l;
        int         d, k;
        longint     s, r;
        logic       o;
        @(negedge clk);
        ena = 1'b0; clr = 1'b1;
        idle(1);
        for (int i = 0; i < 4; i++) model_acc[i] = 0;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                idle(1);
            end else begin
                c = 2'($urandom_range(0, 3));
                f = ($urandom_range(0, 2) == 0);
                l = ($urandom_range(0, 2) == 0);
                d = int'($urandom_range(0, 65535)) - 32768;
                k = int'($urandom_range(0, 65535)) - 32768;
                tap(f, l, c, d, k);
                s = longint'(d) * longint'(k);
                if (!f) s = s + model_acc[c];
                s = s <<< 28;
                s = s >>> 28;
                model_acc[c] = s;
                if (l) begin
                    r = (s + 16384) >>> 15;
                    o = 1'b0;
                    if (r > 32767) begin r = 32767; o = 1'b1; end
                    else if (r < -32768) begin r = -32768; o = 1'b1; end
                    expect_res(int'(r), c, o);
                end
            end
        end
        drain("random");
    endtask

    initial begin
        rst_n = 1'b0; clr = 1'b0; ena = 1'b0; ena5 = 1'b0; first = 1'b0; last = 1'b0;
        ch = '0; ch5 = '0; data = '0; coef = '0;
        test_reset;
        test_basic;
        test_rounding;
        test_saturation;
        test_interleave;
        test_bubbles;
        test_clear;
        test_drop;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not complete within time limit");
        $fatal(1, "timeout");
    end

endmodule
